saturate_round_pipe: RTL and testbench
======================================

// Module: saturate_round_pipe
// PURPOSE
//  Multi-lane, pipelined fixed-point requantiser. Takes LANES signed IN_WIDTH accumulator
//  words and shifts each right by SHIFT fraction bits, using a selectable rounding mode.
//  Clamps each result to signed OUT_WIDTH and counts saturation events.
//  Sits between the MAC array accumulators and the result buffer of the block matmul datapath.
//  Uses a valid/ready handshake so that result-buffer backpressure stalls the whole pipeline.
// PARAMETERS
//  IN_WIDTH   32  signed input width per lane (accumulator format)
//  OUT_WIDTH  16  signed output width per lane
//  SHIFT       8  fraction bits dropped (1..IN_WIDTH-OUT_WIDTH)
//  LANES       4  parallel lanes per beat
//  CNT_WIDTH  16  width of the saturation event counter
// PORTS
//  clk        in   1                  clock, rising edge
//  rst_n      in   1                  synchronous, active-low reset
//  in_valid   in   1                  input beat valid
//  in_ready   out  1                  block can accept a beat this cycle
//  in_data    in   LANES*IN_WIDTH     lane k at [k*IN_WIDTH +: IN_WIDTH], two's complement
//  in_mode    in   2                  0=truncate(floor) 1=round-half-up 2=round-half-even 3=reserved(=truncate)
//  out_valid  out  1                  output beat valid
//  out_ready  in   1                  downstream accepts beat
//  out_data   out  LANES*OUT_WIDTH    lane k at [k*OUT_WIDTH +: OUT_WIDTH]
//  out_sat    out  LANES              per-lane flag: this lane was clamped in this beat
//  sat_count  out  CNT_WIDTH          count of beats with any lane clamped; sticks at all-ones
//  sat_clear  in   1                  synchronous clear of sat_count
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): both stage valids=0, out_valid=0, out_data=0,
//    out_sat=0, sat_count=0. In-flight beats are discarded. in_ready=1 in the cycle after reset.
//  - Pipeline: S1 = bias add, S2 = shift + clamp. Registered outputs.
//    Latency is 2 cycles from in_valid&&in_ready to out_valid. Throughput is 1 beat/cycle.
//  - Handshake: a stage advances when it is empty or the next stage advances.
//    in_ready = !s1_valid || s2_advance, and it is combinational from out_ready.
//    out_data, out_sat and out_valid hold stable while out_valid && !out_ready.
//    No beat is lost or duplicated.
//  - in_mode is captured with its beat and travels with it. The mode may change every beat.
//  - Per lane, S1 works at IN_WIDTH+1 bits to absorb the bias carry:
//    mode0 bias=0
//    mode1 bias=2^(SHIFT-1)
//    mode2 bias=2^(SHIFT-1)-1+x[SHIFT]
//  - S2: y = (x+bias) >>> SHIFT (arithmetic). If y > 2^(OUT_WIDTH-1)-1, output 0x7FF..F with sat=1.
//    If y < -2^(OUT_WIDTH-1), output 0x800..0 with sat=1. Otherwise output y[OUT_WIDTH-1:0] with sat=0.
//    A value that lands exactly on a limit is not saturation.
//  - sat_count increments by 1 on an output handshake (out_valid&&out_ready) with |out_sat.
//    It does not increment at all-ones.
//    sat_clear wins over a simultaneous increment, so the result is 0.
//  - Reset wins over all other inputs.
// STRUCTURE
//  - Package sat_pkg holds the rounding-mode localparams (RND_TRUNC, RND_HALF_UP, RND_HALF_EVEN)
//    and a clamp function sat_clamp(value, OUT_WIDTH).
//  - One sub-module, sat_lane, holds the combinational per-lane bias and clamp logic.
//    It is instantiated LANES times with a generate loop.
//  - The top level owns the stage registers, the valid/ready control and sat_count.
//    Stage registers follow the team's register style with synchronous active-low reset.
// TESTING (IN=32, OUT=16, SHIFT=8, LANES=4, out_ready=1 unless stated)
//  1 lane0 = 0x00012380, modes 0/1/2 -> 0x0123/0x0124/0x0124.
//    lane0 = 0x00012280, modes 0/1/2 -> 0x0122/0x0123/0x0122. Each appears 2 cycles after acceptance.
//  2 Clamp, mode0: 0x00800000 -> 0x7FFF sat=1; 0xFF800000 -> 0x8000 sat=0;
//    0xFF7FFFFF -> 0x8000 sat=1. sat_count=2 after these beats.
//  3 Rounding carry into overflow: 0x007FFF80 in mode1 -> 0x7FFF sat=1; in mode0 -> 0x7FFF sat=0.
//    0xFFFFFF80 in mode1 -> 0x0000.
//  4 Backpressure: stream 8 beats, hold out_ready=0 for cycles 3..6, random bursts afterwards.
//    Required: in_ready drops once both stages are full, output stays stable while stalled,
//    and all 8 beats arrive in order with no drop or duplicate.
//  5 Counter: force 2^16+3 saturating beats -> sat_count=0xFFFF.
//    Pulse sat_clear on the same cycle as a saturating handshake -> sat_count=0.
//  6 Reset mid-stream: assert rst_n=0 for 1 cycle with both stages full.
//    Required next cycle: out_valid=0, out_data=0, sat_count=0, in_ready=1.
//    The first new beat emerges with latency 2.

Source files
------------

// File: rtl/saturate_round_pipe_pkg.sv
// Shared rounding-mode codes and clamp helper
// for the saturate/round requantiser pipeline.
package sat_pkg;

  localparam logic [1:0] RND_TRUNC     = 2'd0;
  localparam logic [1:0] RND_HALF_UP   = 2'd1;
  localparam logic [1:0] RND_HALF_EVEN = 2'd2;

  // Clamp a sign-extended value into a signed ow-bit range.
  function automatic logic signed [63:0] sat_clamp(
    input logic signed [63:0] value,
    input int unsigned        ow
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/saturate_round_pipe_if.sv
// Valid/ready bundle for the requantiser:
// input beat channel and output beat channel.
interface saturate_round_pipe_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16,
  parameter int LANES     = 4
);

  logic                       in_valid;
  logic                       in_ready;
  logic [LANES*IN_WIDTH-1:0]  in_data;
  logic [1:0]                 in_mode;
  logic                       out_valid;
  logic                       out_ready;
  logic [LANES*OUT_WIDTH-1:0] out_data;
  logic [LANES-1:0]           out_sat;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

endinterface

// File: rtl/saturate_round_pipe_lane.sv
// Per-lane combinational logic: rounding bias
// add (stage 1) and shift plus clamp (stage 2).
module sat_lane
  import sat_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 8
) (
  input  logic [1:0]                mode,
  input  logic signed [IN_WIDTH-1:0] x,
  output logic signed [IN_WIDTH:0]   sum,
  input  logic signed [IN_WIDTH:0]   acc,
  output logic [OUT_WIDTH-1:0]       y,
  output logic                       sat
);

  localparam int SW = IN_WIDTH + 1;

  logic [SW-1:0]        half;
  logic [SW-1:0]        bias;
  logic signed [SW-1:0] shifted;
  logic signed [63:0]   wide;
  logic signed [63:0]   clamped;

  // Select rounding bias and add it one bit wider
  always_comb begin
    half          = '0;
    half[SHIFT-1] = 1'b1;
    bias          = '0;
    unique case (1'b1)
      (mode == RND_HALF_UP):
        bias = half;
      (mode == RND_HALF_EVEN):
        bias = half - SW'(1) + SW'(x[SHIFT]);
      default:
        bias = '0;
    endcase
    sum = $signed({x[IN_WIDTH-1], x} + bias);
  end

  // Arithmetic shift, then clamp to output range
  always_comb begin
    shifted = acc >>> SHIFT;
    wide    = {{(64-SW){shifted[SW-1]}}, shifted};
    clamped = sat_clamp(wide, OUT_WIDTH);
    y       = clamped[OUT_WIDTH-1:0];
    sat     = (clamped != wide);
  end

endmodule

// File: rtl/saturate_round_pipe.sv
// Two-stage multi-lane requantiser with
// valid/ready backpressure and saturation count.
module saturate_round_pipe
  import sat_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 8,
  parameter int LANES     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  saturate_round_pipe_if.slave io,
  output logic [CNT_WIDTH-1:0] sat_count,
  input  logic                 sat_clear
);

  localparam int SW = IN_WIDTH + 1;

  logic                       s1_valid_q, s1_valid_d;
  logic [LANES*SW-1:0]        s1_acc_q, s1_acc_d;
  logic                       out_valid_q, out_valid_d;
  logic [LANES*OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [LANES-1:0]           out_sat_q, out_sat_d;
  logic [CNT_WIDTH-1:0]       sat_count_q, sat_count_d;

  logic [LANES*SW-1:0]        sum_all;
  logic [LANES*OUT_WIDTH-1:0] y_all;
  logic [LANES-1:0]           sat_all;
  logic                       s1_adv;
  logic                       s2_adv;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    sat_lane #(
      .IN_WIDTH (IN_WIDTH),
      .OUT_WIDTH(OUT_WIDTH),
      .SHIFT    (SHIFT)
    ) u_lane (
      .mode(io.in_mode),
      .x   (io.in_data[k*IN_WIDTH +: IN_WIDTH]),
      .sum (sum_all[k*SW +: SW]),
      .acc (s1_acc_q[k*SW +: SW]),
      .y   (y_all[k*OUT_WIDTH +: OUT_WIDTH]),
      .sat (sat_all[k])
    );
  end

  // Stage advance, next-state of both stages and counter
  always_comb begin
    s2_adv      = !out_valid_q || io.out_ready;
    s1_adv      = !s1_valid_q || s2_adv;
    s1_valid_d  = s1_valid_q;
    s1_acc_d    = s1_acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    sat_count_d = sat_count_q;
    if (s1_adv) begin
      s1_valid_d = io.in_valid;
      if (io.in_valid) s1_acc_d = sum_all;
    end
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = y_all;
        out_sat_d  = sat_all;
      end
    end
    if (sat_clear) begin
      sat_count_d = '0;
    end else if (out_valid_q && io.out_ready
                 && (|out_sat_q)
                 && (sat_count_q != '1)) begin
      sat_count_d = sat_count_q + CNT_WIDTH'(1);
    end
  end

  // Stage registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_acc_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_acc_q    <= s1_acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign io.in_ready  = s1_adv;
  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;
  assign io.out_sat   = out_sat_q;
  assign sat_count    = sat_count_q;

endmodule

// File: tb/tb_saturate_round_pipe.sv
// Scoreboard bench for saturate_round_pipe:
// directed corner beats plus randomized traffic.
module tb_saturate_round_pipe;

  localparam int IW = 32;
  localparam int OW = 16;
  localparam int SH = 8;
  localparam int L  = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sat_clear = 1'b0;
  logic [CW-1:0] sat_count;

  always #5 clk = ~clk;

  saturate_round_pipe_if #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .LANES(L)
  ) bus ();

  saturate_round_pipe #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT(SH),
    .LANES(L), .CNT_WIDTH(CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io       (bus),
    .sat_count(sat_count),
    .sat_clear(sat_clear)
  );

  typedef struct {
    logic [L*OW-1:0] data;
    logic [L-1:0]    sat;
    int              cyc;
    bit              lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   chk_lat = 1'b0;
  int   cnt_m = 0;
  bit   rnd_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // Reference: floor division, then mode-specific
  // rounding decision from the remainder, then clamp.
  task automatic ref_lane(input  logic [31:0] x,
                          input  logic [1:0]  m,
                          output logic [15:0] y,
                          output logic        s);
    longint v, q, r;
    v = longint'($signed(x));
    q = v / 256;
    if (v < 0 && q * 256 != v) q = q - 1;
    r = v - q * 256;
    if (m == 2'd1 && r >= 128) q = q + 1;
    if (m == 2'd2 && (r > 128 || (r == 128 && (q % 2) != 0)))
      q = q + 1;
    if (q > 32767) begin
      y = 16'h7FFF; s = 1'b1;
    end else if (q < -32768) begin
      y = 16'h8000; s = 1'b1;
    end else begin
      y = q[15:0]; s = 1'b0;
    end
  endtask

  task automatic send(input logic [L*IW-1:0] d,
                      input logic [1:0]      m,
                      input bit              directed,
                      input logic [L*OW-1:0] dexp,
                      input logic [L-1:0]    dsat);
    exp_t        e;
    int          n;
    logic [15:0] y;
    logic        s;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_mode  = m;
    if (directed) begin
      e.data = dexp;
      e.sat  = dsat;
    end else begin
      for (int k = 0; k < L; k++) begin
        ref_lane(d[k*IW +: IW], m, y, s);
        e.data[k*OW +: OW] = y;
        e.sat[k] = s;
      end
    end
    n = 0;
    @(negedge clk);
    while (!(bus.in_ready && rst_n) && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stuck at %0b, expected 1",
               bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    e.cyc = cyc;
    e.lat = chk_lat;
    @(posedge clk);
    sb.push_back(e);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send_d(input logic [31:0] x,
                        input logic [1:0]  m,
                        input logic [15:0] y0,
                        input logic        s0);
    send({96'd0, x}, m, 1'b1, {48'd0, y0}, {3'd0, s0});
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while (sb.size() != 0 && n < 500) begin
      n++;
      @(negedge clk);
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] gen_word();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: return r;
      1: return {{8{r[23]}}, r[23:0]};
      2: return {{12{r[19]}}, r[19:8], 8'h80};
      default: return r[0] ? 32'h007FFF00 + 32'(r[15:8])
                           : 32'hFF800000 - 32'(r[15:8]);
    endcase
  endfunction

  function automatic logic [L*IW-1:0] gen_beat();
    logic [L*IW-1:0] d;
    for (int k = 0; k < L; k++) d[k*IW +: IW] = gen_word();
    return d;
  endfunction

  // Monitor: pop and compare on each output handshake,
  // track sat_count, stall stability and in_ready.
  logic [L*OW-1:0] held_d;
  logic [L-1:0]    held_s;
  bit              prev_stall = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    bit   hs;
    bit   hs_sat;
    if (!rst_n) begin
      sb.delete();
      cnt_m = 0;
      prev_stall = 1'b0;
    end else begin
      check("sat_count", 64'(sat_count), 64'(cnt_m));
      check("in_ready", 64'(bus.in_ready),
            64'(!(sb.size() == 2 && !bus.out_ready)));
      if (prev_stall) begin
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        check("stall_data", bus.out_data, held_d);
        check("stall_sat", 64'(bus.out_sat), 64'(held_s));
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      held_d = bus.out_data;
      held_s = bus.out_sat;
      hs = bus.out_valid && bus.out_ready;
      hs_sat = 1'b0;
      if (hs) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_beat: got %0h, expected no beat",
                   bus.out_data);
        end else begin
          e = sb.pop_front();
          check("out_data", bus.out_data, e.data);
          check("out_sat", 64'(bus.out_sat), 64'(e.sat));
          if (e.lat) check("latency", 64'(cyc - e.cyc), 64'd2);
          hs_sat = |e.sat;
        end
      end
      if (sat_clear) cnt_m = 0;
      else if (hs && hs_sat && cnt_m != 65535) cnt_m++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time expired");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = 2'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_out_sat", 64'(bus.out_sat), 64'd0);
    check("rst_sat_count", 64'(sat_count), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Rounding modes on ties and non-ties
    chk_lat = 1'b1;
    send_d(32'h00012380, 2'd0, 16'h0123, 1'b0);
    send_d(32'h00012380, 2'd1, 16'h0124, 1'b0);
    send_d(32'h00012380, 2'd2, 16'h0124, 1'b0);
    send_d(32'h00012280, 2'd0, 16'h0122, 1'b0);
    send_d(32'h00012280, 2'd1, 16'h0123, 1'b0);
    send_d(32'h00012280, 2'd2, 16'h0122, 1'b0);
    send_d(32'h00012280, 2'd3, 16'h0122, 1'b0);
    drain();

    // Clamp limits
    send_d(32'h00800000, 2'd0, 16'h7FFF, 1'b1);
    send_d(32'hFF800000, 2'd0, 16'h8000, 1'b0);
    send_d(32'hFF7FFFFF, 2'd0, 16'h8000, 1'b1);
    drain();
    check("sat_count_after_clamp", 64'(sat_count), 64'd2);

    // Rounding carry into overflow
    send_d(32'h007FFF80, 2'd1, 16'h7FFF, 1'b1);
    send_d(32'h007FFF80, 2'd0, 16'h7FFF, 1'b0);
    send_d(32'hFFFFFF80, 2'd1, 16'h0000, 1'b0);
    drain();
    chk_lat = 1'b0;

    // Backpressure window then random bursts
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(gen_beat(), 2'($urandom_range(0, 3)),
               1'b0, '0, '0);
      end
      begin
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Randomized traffic with random backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++)
          send(gen_beat(), 2'($urandom_range(0, 3)),
               1'b0, '0, '0);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          bus.out_ready = ($urandom_range(0, 9) < 7);
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Counter sticks at all-ones
    for (int i = 0; i < 65539; i++)
      send({4{32'h7FFFFFFF}}, 2'd0, 1'b1,
           {4{16'h7FFF}}, 4'hF);
    drain();
    check("sat_count_sticky", 64'(sat_count), 64'hFFFF);

    // Clear coinciding with a saturating handshake
    send_d(32'h7FFFFFFF, 2'd0, 16'h7FFF, 1'b1);
    @(posedge clk);
    #1 sat_clear = 1'b1;
    @(negedge clk);
    check("clear_with_hs", 64'(bus.out_valid && bus.out_ready),
          64'd1);
    @(posedge clk);
    #1 sat_clear = 1'b0;
    @(negedge clk);
    check("sat_count_cleared", 64'(sat_count), 64'd0);
    @(posedge clk);
    #1;
    send_d(32'h80000000, 2'd1, 16'h8000, 1'b1);
    drain();

    // Reset with both stages full
    bus.out_ready = 1'b0;
    send_d(32'h00001000, 2'd0, 16'h0010, 1'b0);
    send_d(32'h00002000, 2'd0, 16'h0020, 1'b0);
    @(negedge clk);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_out_data", bus.out_data, 64'd0);
    check("mid_rst_sat_count", 64'(sat_count), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    chk_lat = 1'b1;
    send_d(32'h00004580, 2'd2, 16'h0046, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
